elastic_alu_stage: RTL and testbench
====================================

ELASTIC_ALU_STAGE -- requirements
Module: elastic_alu

Interface
REQ-001 Parameter DATA_WIDTH, default 32: operand, result and memory data width.
REQ-002 Parameter ADDRESS_WIDTH, default 32: memory address width.
REQ-003 Parameter OPERATION_BIT_LENGTH, default 4: op code width.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 reset_n  input  1  synchronous, active-high reset; the port name is kept from the codebase and does not indicate polarity.
REQ-006 input_data_1, input_data_2  input  DATA_WIDTH  operands A and B.
REQ-007 op  input  OPERATION_BIT_LENGTH  operation code for the token at the input.
REQ-008 const_data  input  DATA_WIDTH  constant operand.
REQ-009 valid_input  input  1  upstream token valid.
REQ-010 stop_input  output  1  back-pressure to upstream.
REQ-011 output_data  output  DATA_WIDTH  registered result.
REQ-012 valid_output  output  1  result token valid.
REQ-013 stop_output  input  1  back-pressure from downstream.
REQ-014 switch_context  output  1  one-cycle pulse marking the downstream transfer of a result.
REQ-015 memory_read_address  output  ADDRESS_WIDTH, and memory_read_data  input  DATA_WIDTH: asynchronous read port.
REQ-016 memory_write_address  output  ADDRESS_WIDTH, memory_write_data  output  DATA_WIDTH, and memory_write  output  1: synchronous write port.

Function
REQ-017 The block has one output token register: output_data plus valid_output; "full" means valid_output=1.
REQ-018 stop_input = valid_output (combinational), so a new input is never accepted in the cycle its predecessor leaves; maximum throughput is 1 token per 2 cycles.
REQ-019 Accept = valid_input & ~stop_input. On accept, the result is registered into output_data and valid_output is set on the next edge; latency is 1 cycle.
REQ-020 Transfer = valid_output & ~stop_output. On transfer, valid_output is cleared on the next edge, and switch_context = transfer (combinational); output_data stays stable while switch_context is high.
REQ-021 While valid_output=1 and stop_output=1, output_data and valid_output hold unchanged for any number of cycles.
REQ-022 Op codes (results wrap modulo 2^DATA_WIDTH):
- 0 NOP: result 0.
- 1 ADD: A+B.
- 2 SUB: A-B.
- 3 MUL: low DATA_WIDTH bits of A*B.
- 4 SHL: A<<B[4:0].
- 5 SHR: logical A>>B[4:0].
- 6 AND, 7 OR, 8 XOR: bitwise.
- 9 CONST: const_data.
- 10 LOAD: memory_read_data.
- 11 STORE: result B.
- 12–15: result 0.
REQ-023 memory_read_address = A[ADDRESS_WIDTH-1:0], combinational at all times; for LOAD, memory_read_data is sampled on the accept edge.
REQ-024 memory_write = accept & (op==STORE), combinational; memory_write_address = A[ADDRESS_WIDTH-1:0]; memory_write_data = B; the write occurs exactly once per accepted STORE token.
REQ-025 Every accepted token, including NOP and STORE, produces exactly one output token.
REQ-026 op and const_data are used only in the accept cycle; changing them while the output register is full has no effect on the stored result.

Reset
REQ-027 While reset_n=1: output_data=0 and valid_output=0 on the next edge; switch_context, memory_write and stop_input are 0 because they derive from these registers.
REQ-028 Reset wins over a simultaneous accept or transfer; a token in flight is discarded and no memory write is issued in that cycle.

Configuration
REQ-029 Macro ELASTIC_ALU_MUL_EN defined: MUL is implemented as in REQ-022.
REQ-030 Macro ELASTIC_ALU_MUL_EN undefined: no multiplier is synthesized and MUL yields result 0; handshake timing is identical in both builds.

Structure
REQ-031 The shared package holds DATA_WIDTH, ADDRESS_WIDTH, OPERATION_BIT_LENGTH and the op-code enum/constants from REQ-022.
REQ-032 One combinational sub-module, alu_core, computes the result from (op, A, B, const_data, memory_read_data); elastic_alu wraps it with the handshake register and the memory port logic.

Verification
REQ-033 ADD: A=5, B=7, valid_input pulse, stop_output=0 -> next cycle valid_output=1, output_data=12, switch_context=1 for exactly 1 cycle.
REQ-034 Stall: SUB with A=3, B=5 and stop_output=1 for 4 cycles -> output_data=0xFFFFFFFE held; stop_input=1 throughout; after stop_output drops, one switch_context pulse.
REQ-035 STORE then LOAD: STORE A=0x10, B=42 -> one cycle with memory_write=1, address 0x10, data 42; then LOAD A=0x10 with a model returning 42 -> output_data=42.
REQ-036 Back-to-back: valid_input held high with 3 ADD tokens -> exactly 3 outputs, accepts 2 cycles apart, none lost or duplicated.
REQ-037 Reset mid-operation: reset_n=1 while full and stopped -> valid_output=0 next cycle, no switch_context pulse, no memory write.
REQ-038 MUL: A=6, B=7 -> 42 with ELASTIC_ALU_MUL_EN defined; 0 without it.

Source files
------------

// File: rtl/elastic_alu_stage_pkg.sv
// Shared widths and op-code encoding for the elastic ALU stage.
package elastic_alu_stage_pkg;

  localparam int unsigned DATA_WIDTH           = 32;
  localparam int unsigned ADDRESS_WIDTH        = 32;
  localparam int unsigned OPERATION_BIT_LENGTH = 4;

  // Codes 12..15 are unassigned and yield a zero result.
  typedef enum logic [OPERATION_BIT_LENGTH-1:0] {
    OP_NOP   = 4'd0,
    OP_ADD   = 4'd1,
    OP_SUB   = 4'd2,
    OP_MUL   = 4'd3,
    OP_SHL   = 4'd4,
    OP_SHR   = 4'd5,
    OP_AND   = 4'd6,
    OP_OR    = 4'd7,
    OP_XOR   = 4'd8,
    OP_CONST = 4'd9,
    OP_LOAD  = 4'd10,
    OP_STORE = 4'd11
  } alu_op_e;

endpackage

// File: rtl/elastic_alu_stage_alu_core.sv
// Combinational result datapath for the elastic ALU stage.
// MUL is only built when ELASTIC_ALU_MUL_EN is defined; otherwise it yields 0.
module alu_core
  import elastic_alu_stage_pkg::*;
#(
  parameter int unsigned DATA_WIDTH           = elastic_alu_stage_pkg::DATA_WIDTH,
  parameter int unsigned OPERATION_BIT_LENGTH = elastic_alu_stage_pkg::OPERATION_BIT_LENGTH
) (
  input  logic [OPERATION_BIT_LENGTH-1:0] op,
  input  logic [DATA_WIDTH-1:0]           a,
  input  logic [DATA_WIDTH-1:0]           b,
  input  logic [DATA_WIDTH-1:0]           const_data,
  input  logic [DATA_WIDTH-1:0]           memory_read_data,
  output logic [DATA_WIDTH-1:0]           result
);

  always_comb begin
    result = '0;
    case (op)
      OP_ADD:   result = a + b;
      OP_SUB:   result = a - b;
`ifdef ELASTIC_ALU_MUL_EN
      OP_MUL:   result = a * b;
`endif
      OP_SHL:   result = a << b[4:0];
      OP_SHR:   result = a >> b[4:0];
      OP_AND:   result = a & b;
      OP_OR:    result = a | b;
      OP_XOR:   result = a ^ b;
      OP_CONST: result = const_data;
      OP_LOAD:  result = memory_read_data;
      OP_STORE: result = b;
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/elastic_alu_stage.sv
// Single-register elastic ALU stage with async memory read and sync memory write.
// Optional multiplier controlled by macro ELASTIC_ALU_MUL_EN (see alu_core).
module elastic_alu_stage
  import elastic_alu_stage_pkg::*;
#(
  parameter int unsigned DATA_WIDTH           = elastic_alu_stage_pkg::DATA_WIDTH,
  parameter int unsigned ADDRESS_WIDTH        = elastic_alu_stage_pkg::ADDRESS_WIDTH,
  parameter int unsigned OPERATION_BIT_LENGTH = elastic_alu_stage_pkg::OPERATION_BIT_LENGTH
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [DATA_WIDTH-1:0]           input_data_1,
  input  logic [DATA_WIDTH-1:0]           input_data_2,
  input  logic [OPERATION_BIT_LENGTH-1:0] op,
  input  logic [DATA_WIDTH-1:0]           const_data,
  input  logic                            valid_input,
  output logic                            stop_input,
  output logic [DATA_WIDTH-1:0]           output_data,
  output logic                            valid_output,
  input  logic                            stop_output,
  output logic                            switch_context,
  output logic [ADDRESS_WIDTH-1:0]        memory_read_address,
  input  logic [DATA_WIDTH-1:0]           memory_read_data,
  output logic [ADDRESS_WIDTH-1:0]        memory_write_address,
  output logic [DATA_WIDTH-1:0]           memory_write_data,
  output logic                            memory_write
);

  logic                  accept;
  logic                  transfer;
  logic [DATA_WIDTH-1:0] result;

  alu_core #(
    .DATA_WIDTH           (DATA_WIDTH),
    .OPERATION_BIT_LENGTH (OPERATION_BIT_LENGTH)
  ) u_alu_core (
    .op               (op),
    .a                (input_data_1),
    .b                (input_data_2),
    .const_data       (const_data),
    .memory_read_data (memory_read_data),
    .result           (result)
  );

  // Reset is folded into the handshake so it also suppresses the memory write
  // and the switch_context pulse in the reset cycle.
  assign stop_input     = valid_output;
  assign accept         = valid_input & ~valid_output & ~reset_n;
  assign transfer       = valid_output & ~stop_output & ~reset_n;
  assign switch_context = transfer;

  assign memory_read_address  = input_data_1[ADDRESS_WIDTH-1:0];
  assign memory_write_address = input_data_1[ADDRESS_WIDTH-1:0];
  assign memory_write_data    = input_data_2;
  assign memory_write         = accept & (op == OP_STORE);

  always_ff @(posedge clk) begin
    if (reset_n) begin
      output_data  <= '0;
      valid_output <= 1'b0;
    end else if (accept) begin
      output_data  <= result;
      valid_output <= 1'b1;
    end else if (transfer) begin
      valid_output <= 1'b0;
    end
  end

endmodule

// File: tb/tb_elastic_alu_stage.sv
// Scoreboard bench for elastic_alu_stage: directed scenarios plus randomized traffic.
module tb_elastic_alu_stage;
  import elastic_alu_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] input_data_1, input_data_2, const_data;
  logic [3:0]  op;
  logic        valid_input, stop_input, valid_output, stop_output, switch_context;
  logic [31:0] output_data;
  logic [31:0] memory_read_address, memory_read_data;
  logic [31:0] memory_write_address, memory_write_data;
  logic        memory_write;

  always #5 clk = ~clk;

  elastic_alu_stage #(
    .DATA_WIDTH           (32),
    .ADDRESS_WIDTH        (32),
    .OPERATION_BIT_LENGTH (4)
  ) dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .input_data_1         (input_data_1),
    .input_data_2         (input_data_2),
    .op                   (op),
    .const_data           (const_data),
    .valid_input          (valid_input),
    .stop_input           (stop_input),
    .output_data          (output_data),
    .valid_output         (valid_output),
    .stop_output          (stop_output),
    .switch_context       (switch_context),
    .memory_read_address  (memory_read_address),
    .memory_read_data     (memory_read_data),
    .memory_write_address (memory_write_address),
    .memory_write_data    (memory_write_data),
    .memory_write         (memory_write)
  );

  // 16-word memory seen by the DUT, indexed by the low address bits
  logic [31:0] mem [16];
  always_comb memory_read_data = mem[memory_read_address[3:0]];
  always @(posedge clk) begin
    if (reset_n) begin
      for (int i = 0; i < 16; i++) mem[i] <= '0;
    end else if (memory_write) begin
      mem[memory_write_address[3:0]] <= memory_write_data;
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [3:0] o, input logic [31:0] a, b, c, m);
    case (o)
      1:  return a + b;
      2:  return a - b;
`ifdef ELASTIC_ALU_MUL_EN
      3:  return a * b;
`endif
      4:  return a << (b % 32);
      5:  return a >> (b % 32);
      6:  return a & b;
      7:  return a | b;
      8:  return a ^ b;
      9:  return c;
      10: return m;
      11: return b;
      default: return 32'd0;
    endcase
  endfunction

  // Reference state: one-slot pipeline occupancy, expected results, memory image
  bit          full_m = 1'b0;
  logic [31:0] exp_q [$];
  logic [31:0] model_mem [16];
  int          cyc = 0;
  int          sc_dut = 0;
  int          acc_log [$];

  always @(negedge clk) begin
    bit acc, xfer, st;
    cyc++;
    xfer = full_m && !stop_output && !reset_n;
    acc  = valid_input && !full_m && !reset_n;
    st   = acc && (op == 4'd11);
    chk("stop_input", {31'd0, stop_input}, {31'd0, full_m});
    chk("valid_output", {31'd0, valid_output}, {31'd0, full_m});
    chk("switch_context", {31'd0, switch_context}, {31'd0, xfer});
    chk("memory_write", {31'd0, memory_write}, {31'd0, st});
    if (st) begin
      chk("mem_wr_addr", memory_write_address, input_data_1);
      chk("mem_wr_data", memory_write_data, input_data_2);
    end
    if (full_m) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL scoreboard_empty actual=%0h expected=none", output_data);
      end else begin
        chk("output_data", output_data, exp_q[0]);
      end
    end
    if (switch_context === 1'b1) sc_dut++;

    if (reset_n) begin
      exp_q.delete();
      full_m = 1'b0;
      for (int i = 0; i < 16; i++) model_mem[i] = '0;
    end else if (acc) begin
      exp_q.push_back(ref_alu(op, input_data_1, input_data_2, const_data,
                              model_mem[input_data_1[3:0]]));
      acc_log.push_back(cyc);
      full_m = 1'b1;
      if (st) model_mem[input_data_1[3:0]] = input_data_2;
    end else if (xfer) begin
      void'(exp_q.pop_front());
      full_m = 1'b0;
    end
  end

  bit rand_stop = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_stop) stop_output = ($urandom_range(0, 3) == 0);
  endtask

  task automatic scramble();
    op = 4'($urandom); input_data_1 = $urandom; input_data_2 = $urandom; const_data = $urandom;
  endtask

  task automatic send(input logic [3:0] o, input logic [31:0] a, b, c, input bit hold);
    bit got = 1'b0;
    op = o; input_data_1 = a; input_data_2 = b; const_data = c; valid_input = 1'b1;
    for (int n = 0; n < 60 && !got; n++) begin
      @(negedge clk);
      got = !stop_input && !reset_n;
      tick();
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL send_timeout actual=not_accepted expected=accepted op=%0d", o);
    end
    if (!hold) begin
      valid_input = 1'b0;
      scramble();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    reset_n = 1'b1; valid_input = 1'b0; stop_output = 1'b0;
    op = '0; input_data_1 = '0; input_data_2 = '0; const_data = '0;
    repeat (2) tick();
    chk("reset_data", output_data, 32'd0);
    chk("reset_valid", {31'd0, valid_output}, 32'd0);
    reset_n = 1'b0;
    tick();

    // ADD: one-cycle latency and a single switch_context pulse
    s0 = sc_dut;
    send(4'd1, 32'd5, 32'd7, 32'd0, 1'b0);
    chk("add_result", output_data, 32'd12);
    repeat (3) tick();
    chk("add_pulses", sc_dut - s0, 32'd1);

    // Stalled SUB: result and back-pressure held, then one pulse
    stop_output = 1'b1;
    send(4'd2, 32'd3, 32'd5, 32'd0, 1'b0);
    repeat (4) tick();
    chk("stall_data", output_data, 32'hFFFF_FFFE);
    chk("stall_stop_in", {31'd0, stop_input}, 32'd1);
    s0 = sc_dut;
    stop_output = 1'b0;
    repeat (3) tick();
    chk("stall_pulses", sc_dut - s0, 32'd1);

    // STORE then LOAD through the bench memory
    send(4'd11, 32'h10, 32'd42, 32'd0, 1'b0);
    repeat (2) tick();
    send(4'd10, 32'h10, 32'd0, 32'd0, 1'b0);
    chk("load_data", output_data, 32'd42);
    repeat (2) tick();

    // Back-to-back with valid_input held high
    acc_log.delete();
    s0 = sc_dut;
    send(4'd1, 32'd1, 32'd2, 32'd0, 1'b1);
    send(4'd1, 32'd3, 32'd4, 32'd0, 1'b1);
    send(4'd1, 32'd5, 32'd6, 32'd0, 1'b0);
    repeat (3) tick();
    chk("b2b_outputs", sc_dut - s0, 32'd3);
    if (acc_log.size() == 3) begin
      chk("b2b_gap1", acc_log[1] - acc_log[0], 32'd2);
      chk("b2b_gap2", acc_log[2] - acc_log[1], 32'd2);
    end else begin
      total++; bad++;
      $display("FAIL b2b_accepts actual=%0d expected=3", acc_log.size());
    end

    // Reset while full and stopped, with a STORE presented meanwhile
    stop_output = 1'b1;
    send(4'd1, 32'd9, 32'd9, 32'd0, 1'b0);
    tick();
    s0 = sc_dut;
    op = 4'd11; input_data_1 = 32'h3; input_data_2 = 32'hDEAD; valid_input = 1'b1;
    reset_n = 1'b1;
    repeat (2) tick();
    reset_n = 1'b0; valid_input = 1'b0; stop_output = 1'b0;
    chk("rst_valid", {31'd0, valid_output}, 32'd0);
    chk("rst_data", output_data, 32'd0);
    chk("rst_pulses", sc_dut - s0, 32'd0);
    tick();

    // MUL, build dependent
    send(4'd3, 32'd6, 32'd7, 32'd0, 1'b0);
`ifdef ELASTIC_ALU_MUL_EN
    chk("mul_result", output_data, 32'd42);
`else
    chk("mul_result", output_data, 32'd0);
`endif
    repeat (2) tick();

    // Randomized traffic with random downstream stalls and occasional reset
    rand_stop = 1'b1;
    repeat (300) begin
      logic [3:0]  o;
      logic [31:0] a;
      o = 4'($urandom_range(0, 15));
      a = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 15)) : $urandom;
      send(o, a, $urandom, $urandom, 1'b0);
      repeat ($urandom_range(0, 2)) tick();
      if ($urandom_range(0, 40) == 0) begin
        reset_n = 1'b1;
        tick();
        reset_n = 1'b0;
      end
    end
    rand_stop = 1'b0;
    stop_output = 1'b0;
    repeat (5) tick();
    chk("drain", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
